parallel_block_accumulator: RTL and testbench

//   Multi-lane streaming accumulator: sums BLOCK_LEN unsigned samples arriving LANES per beat,

---
 rtl/parallel_block_accumulator_pkg.sv | 17 +
 rtl/parallel_block_accumulator_if.sv | 26 ++
 rtl/parallel_block_accumulator_lane_adder_tree.sv | 54 +++++
 rtl/parallel_block_accumulator.sv | 139 +++++++++++++
 tb/tb_parallel_block_accumulator.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/parallel_block_accumulator_pkg.sv
// Shared defaults and width helpers for the multi-lane block accumulator.
package accum_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_LANES     = 4;
  localparam int DEF_BLOCK_LEN = 1024;
  localparam int DEF_ACC_W     = 32;

  function automatic int lane_sum_w(input int data_w, input int lanes);
    return data_w + $clog2(lanes);
  endfunction

  function automatic int beats_calc(input int block_len, input int lanes);
    return block_len / lanes;
  endfunction

endpackage

// File: rtl/parallel_block_accumulator_if.sv
// Streaming input beat and block-result handshakes of the block accumulator.
interface parallel_block_accumulator_if
  import accum_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES,
  parameter int ACC_W  = DEF_ACC_W
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*DATA_W-1:0]   in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [ACC_W-1:0]          out_sum;
  logic                      out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/parallel_block_accumulator_lane_adder_tree.sv
// Stage 1: sums all lanes of an accepted beat into one registered lane sum,
// carrying the valid and last-beat tags alongside.
module lane_adder_tree
  import accum_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES,
  localparam int SUM_W = lane_sum_w(DATA_W, LANES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_clear,
  input  logic                    i_en,
  input  logic                    i_valid,
  input  logic                    i_last,
  input  logic [LANES*DATA_W-1:0] i_data,
  output logic                    o_valid,
  output logic                    o_last,
  output logic [SUM_W-1:0]        o_sum
);

  logic [DATA_W-1:0] w_lane [LANES];
  logic [SUM_W-1:0]  w_sum;

  // Lanes are masked by valid so undriven data on idle cycles never reaches the sum.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_lane[gi] = i_valid ? i_data[gi*DATA_W +: DATA_W] : '0;
    end
  endgenerate

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      w_sum = w_sum + SUM_W'(w_lane[k]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_sum   <= '0;
    end else if (i_clear) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else if (i_en) begin
      o_valid <= i_valid;
      o_last  <= i_valid && i_last;
      o_sum   <= w_sum;
    end
  end

endmodule

// File: rtl/parallel_block_accumulator.sv
// Multi-lane streaming block accumulator: lane adder stage, block accumulator
// stage with wrap/saturate overflow handling, and a held output register.
module parallel_block_accumulator
  import accum_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LANES     = DEF_LANES,
  parameter int BLOCK_LEN = DEF_BLOCK_LEN,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int SATURATE  = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  parallel_block_accumulator_if.slave   bus
);

  localparam int BEATS = beats_calc(BLOCK_LEN, LANES);
  localparam int SUM_W = lane_sum_w(DATA_W, LANES);
  localparam int CNT_W = $clog2(BEATS);
  localparam int EXT_W = ((SUM_W > ACC_W) ? SUM_W : ACC_W) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  generate
    if (BLOCK_LEN % LANES != 0) begin : g_chk_len
      $error("BLOCK_LEN must be a multiple of LANES");
    end
    if (BEATS < 2) begin : g_chk_beats
      $error("BLOCK_LEN/LANES must be at least 2");
    end
    if (LANES < 1 || (LANES & (LANES - 1)) != 0) begin : g_chk_lanes
      $error("LANES must be a power of 2");
    end
  endgenerate

  logic             w_en;
  logic             w_accept;
  logic             w_beat_last;
  logic [CNT_W-1:0] r_beat_cnt;

  logic             w_s1_valid;
  logic             w_s1_last;
  logic [SUM_W-1:0] w_s1_sum;

  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_s2_last;
  logic [ACC_W-1:0] w_acc_base;
  logic             w_ovf_base;
  logic [EXT_W-1:0] w_acc_sum;
  logic             w_ovf_next;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_load;

  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic             r_out_ovf;

  // The whole pipeline freezes only while a finished result waits on the consumer.
  assign w_en        = !(r_out_valid && !bus.out_ready);
  assign w_accept    = bus.in_valid && w_en && !clear;
  assign w_beat_last = (r_beat_cnt == LAST_BEAT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_beat_cnt <= '0;
    end else if (clear) begin
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      r_beat_cnt <= w_beat_last ? '0 : r_beat_cnt + 1'b1;
    end
  end

  lane_adder_tree #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) u_lane_adder_tree (
    .clk     (clk),
    .reset   (reset),
    .i_clear (clear),
    .i_en    (w_en),
    .i_valid (w_accept),
    .i_last  (w_beat_last),
    .i_data  (bus.in_data),
    .o_valid (w_s1_valid),
    .o_last  (w_s1_last),
    .o_sum   (w_s1_sum)
  );

  // A completed block in stage 2 restarts the accumulation from zero.
  assign w_acc_base = r_s2_last ? '0 : r_acc;
  assign w_ovf_base = r_s2_last ? 1'b0 : r_ovf;
  assign w_acc_sum  = EXT_W'(w_acc_base) + EXT_W'(w_s1_sum);
  assign w_ovf_next = w_ovf_base || (|w_acc_sum[EXT_W-1:ACC_W]);
  assign w_acc_next = ((SATURATE != 0) && w_ovf_next) ? '1 : w_acc_sum[ACC_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_s2_last <= 1'b0;
    end else if (clear) begin
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_s2_last <= 1'b0;
    end else if (w_en) begin
      r_s2_last <= w_s1_valid && w_s1_last;
      if (w_s1_valid) begin
        r_acc <= w_acc_next;
        r_ovf <= w_ovf_next;
      end else if (r_s2_last) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end
    end
  end

  assign w_load = w_en && r_s2_last && !clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= r_acc;
      r_out_ovf   <= r_ovf;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_parallel_block_accumulator.sv
// Directed bench for parallel_block_accumulator with scoreboard queues of expected block results.
module tb_parallel_block_accumulator;
  import accum_pkg::*;

  typedef struct packed {
    logic [31:0] sum;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  int checks = 0;
  int failures = 0;
  int n_out0 = 0;
  int n_out1 = 0;
  int n_out2 = 0;
  int stall0 = 0;
  longint model0 = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  parallel_block_accumulator_if #(.DATA_W(16), .LANES(4), .ACC_W(32)) bus0 ();
  parallel_block_accumulator_if #(.DATA_W(16), .LANES(4), .ACC_W(16)) bus1 ();
  parallel_block_accumulator_if #(.DATA_W(16), .LANES(4), .ACC_W(16)) bus2 ();

  parallel_block_accumulator #(
    .DATA_W(16), .LANES(4), .BLOCK_LEN(1024), .ACC_W(32), .SATURATE(0)
  ) dut0 (.clk(clk), .reset(rst_n), .clear(clear), .bus(bus0));

  parallel_block_accumulator #(
    .DATA_W(16), .LANES(4), .BLOCK_LEN(1024), .ACC_W(16), .SATURATE(0)
  ) dut1 (.clk(clk), .reset(rst_n), .clear(clear), .bus(bus1));

  parallel_block_accumulator #(
    .DATA_W(16), .LANES(4), .BLOCK_LEN(1024), .ACC_W(16), .SATURATE(1)
  ) dut2 (.clk(clk), .reset(rst_n), .clear(clear), .bus(bus2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors: one pop per completed output handshake.
  always @(negedge clk) begin
    if (rst_n && bus0.out_valid === 1'b1 && bus0.out_ready === 1'b1) begin
      exp_t e;
      n_out0++;
      chk("sb0_expected_present", 64'(q0.size() != 0), 64'd1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("sb0_sum", 64'(bus0.out_sum), 64'(e.sum));
        chk("sb0_ovf", 64'(bus0.out_ovf), 64'(e.ovf));
        $display("dut0 result %0d sum=%0h ovf=%0b", n_out0, bus0.out_sum, bus0.out_ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus1.out_valid === 1'b1 && bus1.out_ready === 1'b1) begin
      exp_t e;
      n_out1++;
      chk("sb1_expected_present", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("sb1_sum", 64'(bus1.out_sum), 64'(e.sum));
        chk("sb1_ovf", 64'(bus1.out_ovf), 64'(e.ovf));
        $display("dut1 result %0d sum=%0h ovf=%0b", n_out1, bus1.out_sum, bus1.out_ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus2.out_valid === 1'b1 && bus2.out_ready === 1'b1) begin
      exp_t e;
      n_out2++;
      chk("sb2_expected_present", 64'(q2.size() != 0), 64'd1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        chk("sb2_sum", 64'(bus2.out_sum), 64'(e.sum));
        chk("sb2_ovf", 64'(bus2.out_ovf), 64'(e.ovf));
        $display("dut2 result %0d sum=%0h ovf=%0b", n_out2, bus2.out_sum, bus2.out_ovf);
      end
    end
  end

  // Presents one beat on dut0 and returns 1ns after the edge that accepted it.
  task automatic send_beat0(input logic [63:0] data);
    bit done;
    done = 1'b0;
    bus0.in_valid = 1'b1;
    bus0.in_data  = data;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      done = (bus0.in_ready === 1'b1) && !clear;
      if (!done) stall0++;
      @(posedge clk);
      #1;
    end
    if (!done) chk("beat_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_beats0(input bit rnd, input logic [15:0] val, input int n);
    for (int b = 0; b < n; b++) begin
      logic [63:0] d;
      d = rnd ? {$urandom, $urandom} : {4{val}};
      for (int k = 0; k < 4; k++) model0 += longint'(d[k*16 +: 16]);
      send_beat0(d);
    end
  endtask

  task automatic push_model0();
    exp_t e;
    e.sum = model0[31:0];
    e.ovf = (model0 > 64'h0000_0000_FFFF_FFFF);
    q0.push_back(e);
    model0 = 0;
  endtask

  task automatic idle0();
    bus0.in_valid = 1'b0;
    bus0.in_data  = 'x;
  endtask

  task automatic wait_out(input int e0, input int e1, input int e2);
    for (int c = 0; c < 2000 && (n_out0 < e0 || n_out1 < e1 || n_out2 < e2); c++) begin
      @(posedge clk);
      #1;
    end
    chk("wait_out0_count", 64'(n_out0), 64'(e0));
    chk("wait_out1_count", 64'(n_out1), 64'(e1));
    chk("wait_out2_count", 64'(n_out2), 64'(e2));
  endtask

  initial begin
    logic [63:0] d;
    exp_t blk1;
    exp_t e;

    bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus0.out_valid), 64'd0);
    chk("rst_out_sum", 64'(bus0.out_sum), 64'd0);
    chk("rst_out_ovf", 64'(bus0.out_ovf), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus0.in_ready), 64'd1);

    // 1: all ones, latency of two edges after the last beat
    send_beats0(1'b0, 16'd1, 256);
    push_model0();
    idle0();
    @(posedge clk); #1;
    chk("t1_valid_after_t1", 64'(bus0.out_valid), 64'd0);
    @(posedge clk); #1;
    chk("t1_valid_after_t2", 64'(bus0.out_valid), 64'd1);
    chk("t1_sum", 64'(bus0.out_sum), 64'd1024);
    @(posedge clk); #1;
    chk("t1_single_pulse", 64'(bus0.out_valid), 64'd0);
    chk("t1_out_count", 64'(n_out0), 64'd1);

    // 2: four random blocks back-to-back, no input gaps expected
    stall0 = 0;
    for (int b = 0; b < 4; b++) begin
      send_beats0(1'b1, 16'd0, 256);
      push_model0();
    end
    idle0();
    chk("t2_no_stalls", 64'(stall0), 64'd0);
    wait_out(5, 0, 0);

    // 3: consumer backpressure while block 2 streams
    bus0.out_ready = 1'b0;
    send_beats0(1'b1, 16'd0, 256);
    blk1.sum = model0[31:0];
    blk1.ovf = 1'b0;
    push_model0();
    send_beats0(1'b1, 16'd0, 2);
    d = {$urandom, $urandom};
    for (int k = 0; k < 4; k++) model0 += longint'(d[k*16 +: 16]);
    bus0.in_valid = 1'b1;
    bus0.in_data  = d;
    repeat (5) @(posedge clk);
    #1;
    chk("t3_in_ready_low", 64'(bus0.in_ready), 64'd0);
    chk("t3_out_valid_held", 64'(bus0.out_valid), 64'd1);
    chk("t3_out_sum_held", 64'(bus0.out_sum), 64'(blk1.sum));
    bus0.out_ready = 1'b1;
    send_beat0(d);
    send_beats0(1'b1, 16'd0, 253);
    push_model0();
    idle0();
    wait_out(7, 0, 0);

    // 4: overflow in 16-bit accumulators, wrap and saturate
    e.sum = 32'h0000_FC00; e.ovf = 1'b1; q1.push_back(e);
    e.sum = 32'h0000_FFFF; e.ovf = 1'b1; q2.push_back(e);
    for (int b = 0; b < 256; b++) begin
      bus1.in_valid = 1'b1; bus1.in_data = {4{16'hFFFF}};
      bus2.in_valid = 1'b1; bus2.in_data = {4{16'hFFFF}};
      @(posedge clk);
      #1;
    end
    bus1.in_valid = 1'b0;
    bus2.in_valid = 1'b0;
    wait_out(7, 1, 1);

    // 5: abort a partial block with clear; the beat alongside clear is dropped
    send_beats0(1'b0, 16'd5, 100);
    model0 = 0;
    clear = 1'b1;
    bus0.in_valid = 1'b1;
    bus0.in_data = {4{16'd5}};
    @(posedge clk); #1;
    clear = 1'b0;
    idle0();
    @(posedge clk); #1;
    chk("t5_no_result_after_clear", 64'(bus0.out_valid), 64'd0);
    send_beats0(1'b0, 16'd2, 256);
    push_model0();
    idle0();
    wait_out(8, 1, 1);

    // 6: asynchronous reset while a result is pending
    bus0.out_ready = 1'b0;
    send_beats0(1'b0, 16'd7, 258);
    model0 = 0;
    idle0();
    repeat (2) @(posedge clk);
    #1;
    chk("t6_pending_before_reset", 64'(bus0.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_reset_out_valid", 64'(bus0.out_valid), 64'd0);
    chk("t6_reset_out_sum", 64'(bus0.out_sum), 64'd0);
    chk("t6_reset_out_ovf", 64'(bus0.out_ovf), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus0.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t6_in_ready_after_release", 64'(bus0.in_ready), 64'd1);
    send_beats0(1'b0, 16'd3, 256);
    push_model0();
    idle0();
    wait_out(9, 1, 1);

    repeat (5) @(posedge clk);
    #1;
    chk("final_q0_empty", 64'(q0.size()), 64'd0);
    chk("final_q1_empty", 64'(q1.size()), 64'd0);
    chk("final_q2_empty", 64'(q2.size()), 64'd0);
    chk("final_out0_count", 64'(n_out0), 64'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
